// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared R-type encoding constants, ALU op codes and encoder FSM states
package instr_enc_pkg;
    localparam logic [5:0] OPCODE_R  = 6'b000000;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;
    localparam logic [5:0] FUNC_SLLV = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    typedef enum logic [1:0] {IDLE, WRITE, PAD, DONE} state_e;
endpackage

// File: rtl/alu_func_encoder.sv
// alu_func_encoder: maps a 3-bit ALU operation to the R-type func field
module alu_func_encoder
    import instr_enc_pkg::*;
(
    input  logic [2:0] alu_op,
    output logic [5:0] func
);
    always_comb begin
        func = FUNC_SLLV;
        case (alu_op)
            ALU_AND:  func = FUNC_AND;
            ALU_OR:   func = FUNC_OR;
            ALU_XOR:  func = FUNC_XOR;
            ALU_NOR:  func = FUNC_NOR;
            ALU_ADD:  func = FUNC_ADD;
            ALU_SUB:  func = FUNC_SUB;
            ALU_SLTU: func = FUNC_SLTU;
            default:  func = FUNC_SLLV;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes R-type requests into sequential instruction-memory writes
// INSTR_ENC_NOP_PAD_EN fills the remaining memory with zero words after finish.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              finish,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done
);
`ifdef INSTR_ENC_NOP_PAD_EN
    localparam state_e FIN_STATE = PAD;
`else
    localparam state_e FIN_STATE = DONE;
`endif

    state_e state, state_n;
    logic [ADDR_W-1:0] ptr;
    logic [31:0] word;
    logic [5:0] func;
    logic last;

    assign last = ptr == '1;

    alu_func_encoder u_func (.alu_op(alu_op), .func(func));

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        if (clear) state_n = IDLE;
        else case (state)
            IDLE:  state_n = in_valid ? WRITE : finish ? FIN_STATE : IDLE;
            WRITE: state_n = last ? DONE : IDLE;
`ifdef INSTR_ENC_NOP_PAD_EN
            PAD:   state_n = last ? DONE : PAD;
`endif
            default: state_n = state;
        endcase
    end

    always_comb begin
        in_ready = state == IDLE;
        done = state == DONE;
`ifdef INSTR_ENC_NOP_PAD_EN
        mem_we = (state == WRITE || state == PAD) && !clear;
`else
        mem_we = state == WRITE && !clear;
`endif
        mem_addr = ptr;
        mem_wdata = state == WRITE ? word : '0;
    end

    // ptr saturates on the last address so it never wraps back to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            count <= '0;
            word <= '0;
        end else if (clear) begin
            ptr <= '0;
            count <= '0;
        end else begin
            if (state == IDLE && in_valid) word <= {OPCODE_R, rs, rt, rd, 5'b00000, func};
            if (mem_we) begin
                count <= count + 1'b1;
                if (!last) ptr <= ptr + 1'b1;
            end
        end
    end
endmodule
